// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg : shared encodings, FSM state types and parity helpers for the UART.
// Revision : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   localparam logic [1:0] PARITY_NONE = 2'b00;
   localparam logic [1:0] PARITY_ODD  = 2'b01;
   localparam logic [1:0] PARITY_EVEN = 2'b10;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   localparam int ERR_PARITY = 0;
   localparam int ERR_START  = 1;
   localparam int ERR_STOP   = 2;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4,
      RX_PUSH   = 3'd5
   } rx_state_t;

   function automatic logic parity_enabled(input logic [1:0] ptype);
      return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
   endfunction

   // xor_data is the XOR reduction of the data bits
   function automatic logic parity_bit(input logic [1:0] ptype, input logic xor_data);
      return (ptype == PARITY_ODD) ? ~xor_data : xor_data;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo : synchronous first-word-fall-through FIFO, valid/ready on both sides.
// Revision       : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_valid,
   output logic             push_ready,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   input  logic             pop_ready
);

   localparam int c_addr_w = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the indices match
   logic [c_addr_w:0]  r_wr_ptr;
   logic [c_addr_w:0]  r_rd_ptr;
   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;

   assign w_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                    (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_push  = push_valid && !w_full;
   assign w_pop   = pop_ready && !w_empty;

   assign push_ready = !w_full;
   assign pop_valid  = !w_empty;
   assign pop_data   = r_mem[r_rd_ptr[c_addr_w-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/uart_duplex_fifo.sv
// -----------------------------------------------------------------------------
// uart_duplex_fifo : buffered full-duplex UART with sticky error/overflow flags.
//                    Define UART_LOOPBACK_EN to add the internal loopback port.
// Revision         : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module uart_duplex_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            parity_type,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
`ifdef UART_LOOPBACK_EN
   input  logic                  loopback,
`endif
   input  logic                  rxd,
   output logic                  txd,
   output logic                  tx_active_flag,
   output logic                  rx_active_flag,
   output logic [2:0]            error_flag,
   output logic                  rx_overflow,
   input  logic                  error_clear
);

   import uart_pkg::*;

   localparam int c_tick_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int c_idx_w  = $clog2(DATA_WIDTH);

   logic [c_tick_w-1:0]   r_tick_cnt;
   logic                  w_tick;

   tx_state_t             r_tx_state;
   tx_state_t             w_tx_state_nxt;
   logic [3:0]            r_tx_cnt;
   logic [3:0]            w_tx_cnt_nxt;
   logic [c_idx_w-1:0]    r_tx_idx;
   logic [c_idx_w-1:0]    w_tx_idx_nxt;
   logic [DATA_WIDTH-1:0] r_tx_shift;
   logic [DATA_WIDTH-1:0] w_tx_shift_nxt;
   logic                  r_tx_par;
   logic                  w_tx_par_nxt;
   logic                  w_tx_pop;
   logic [DATA_WIDTH-1:0] w_txf_data;
   logic                  w_txf_valid;
   logic                  w_tx_serial;

   logic                  r_sync1;
   logic                  r_sync2;
   logic                  w_rx_src;
   logic                  w_rx_in;
   rx_state_t             r_rx_state;
   rx_state_t             w_rx_state_nxt;
   logic [3:0]            r_rx_cnt;
   logic [3:0]            w_rx_cnt_nxt;
   logic [c_idx_w-1:0]    r_rx_idx;
   logic [c_idx_w-1:0]    w_rx_idx_nxt;
   logic [DATA_WIDTH-1:0] r_rx_shift;
   logic [DATA_WIDTH-1:0] w_rx_shift_nxt;
   logic                  w_rx_push;
   logic                  w_rxf_ready;

   logic [2:0]            r_err;
   logic [2:0]            w_err_set;
   logic                  r_ovf;
   logic                  w_ovf_set;

   assign w_tick = (r_tick_cnt == c_tick_w'(CLK_DIV - 1));

   always_ff @(posedge clock) begin
      if (reset)       r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   uart_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_data  (tx_data),
      .push_valid (tx_valid),
      .push_ready (tx_ready),
      .pop_data   (w_txf_data),
      .pop_valid  (w_txf_valid),
      .pop_ready  (w_tx_pop)
   );

   // Every non-idle state advances only on ticks and lasts exactly 16 of them
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_cnt_nxt   = r_tx_cnt;
      w_tx_idx_nxt   = r_tx_idx;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_par_nxt   = r_tx_par;
      w_tx_pop       = 1'b0;
      if (w_tick) begin
         if (r_tx_state == TX_IDLE) begin
            if (w_txf_valid) begin
               w_tx_pop       = 1'b1;
               w_tx_shift_nxt = w_txf_data;
               w_tx_par_nxt   = parity_bit(parity_type, ^w_txf_data);
               w_tx_cnt_nxt   = 4'd0;
               w_tx_state_nxt = TX_START;
            end
         end else begin
            w_tx_cnt_nxt = r_tx_cnt + 4'd1;
            if (r_tx_cnt == 4'(OVERSAMPLE - 1)) begin
               case (r_tx_state)
                  TX_START: begin
                     w_tx_idx_nxt   = '0;
                     w_tx_state_nxt = TX_DATA;
                  end
                  TX_DATA: begin
                     if (r_tx_idx == c_idx_w'(DATA_WIDTH - 1)) begin
                        w_tx_state_nxt = parity_enabled(parity_type) ? TX_PARITY : TX_STOP;
                     end else begin
                        w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
                        w_tx_idx_nxt   = r_tx_idx + 1'b1;
                     end
                  end
                  TX_PARITY: w_tx_state_nxt = TX_STOP;
                  TX_STOP: begin
                     if (w_txf_valid) begin
                        w_tx_pop       = 1'b1;
                        w_tx_shift_nxt = w_txf_data;
                        w_tx_par_nxt   = parity_bit(parity_type, ^w_txf_data);
                        w_tx_state_nxt = TX_START;
                     end else begin
                        w_tx_state_nxt = TX_IDLE;
                     end
                  end
                  default: w_tx_state_nxt = TX_IDLE;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_shift <= '0;
         r_tx_par   <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_tx_idx   <= w_tx_idx_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_tx_par   <= w_tx_par_nxt;
      end
   end

   always_comb begin
      w_tx_serial = 1'b1;
      case (r_tx_state)
         TX_START:  w_tx_serial = 1'b0;
         TX_DATA:   w_tx_serial = r_tx_shift[0];
         TX_PARITY: w_tx_serial = r_tx_par;
         default:   w_tx_serial = 1'b1;
      endcase
   end

`ifdef UART_LOOPBACK_EN
   assign w_rx_src = loopback ? w_tx_serial : rxd;
   assign txd      = loopback ? 1'b1 : w_tx_serial;
`else
   assign w_rx_src = rxd;
   assign txd      = w_tx_serial;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= w_rx_src;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_in = r_sync2;

   // Start bit is checked mid-bit; each later bit is sampled 16 ticks apart
   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt;
      w_rx_idx_nxt   = r_rx_idx;
      w_rx_shift_nxt = r_rx_shift;
      w_rx_push      = 1'b0;
      w_err_set      = 3'b000;
      case (r_rx_state)
         RX_IDLE: begin
            if (w_tick && !w_rx_in) begin
               w_rx_cnt_nxt   = 4'd0;
               w_rx_state_nxt = RX_START;
            end
         end
         RX_START: begin
            if (w_tick) begin
               w_rx_cnt_nxt = r_rx_cnt + 4'd1;
               if (r_rx_cnt == 4'(MID_SAMPLE - 1)) begin
                  w_rx_cnt_nxt = 4'd0;
                  if (w_rx_in) begin
                     w_err_set[ERR_START] = 1'b1;
                     w_rx_state_nxt       = RX_IDLE;
                  end else begin
                     w_rx_idx_nxt   = '0;
                     w_rx_state_nxt = RX_DATA;
                  end
               end
            end
         end
         RX_DATA: begin
            if (w_tick) begin
               w_rx_cnt_nxt = r_rx_cnt + 4'd1;
               if (r_rx_cnt == 4'(OVERSAMPLE - 1)) begin
                  w_rx_shift_nxt = {w_rx_in, r_rx_shift[DATA_WIDTH-1:1]};
                  if (r_rx_idx == c_idx_w'(DATA_WIDTH - 1))
                     w_rx_state_nxt = parity_enabled(parity_type) ? RX_PARITY : RX_STOP;
                  else
                     w_rx_idx_nxt = r_rx_idx + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            if (w_tick) begin
               w_rx_cnt_nxt = r_rx_cnt + 4'd1;
               if (r_rx_cnt == 4'(OVERSAMPLE - 1)) begin
                  if (w_rx_in != parity_bit(parity_type, ^r_rx_shift))
                     w_err_set[ERR_PARITY] = 1'b1;
                  w_rx_state_nxt = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (w_tick) begin
               w_rx_cnt_nxt = r_rx_cnt + 4'd1;
               if (r_rx_cnt == 4'(OVERSAMPLE - 1)) begin
                  if (!w_rx_in) w_err_set[ERR_STOP] = 1'b1;
                  w_rx_state_nxt = RX_PUSH;
               end
            end
         end
         RX_PUSH: begin
            w_rx_push      = 1'b1;
            w_rx_state_nxt = RX_IDLE;
         end
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_idx   <= w_rx_idx_nxt;
         r_rx_shift <= w_rx_shift_nxt;
      end
   end

   uart_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_data  (r_rx_shift),
      .push_valid (w_rx_push),
      .push_ready (w_rxf_ready),
      .pop_data   (rx_data),
      .pop_valid  (rx_valid),
      .pop_ready  (rx_ready)
   );

   assign w_ovf_set = w_rx_push && !w_rxf_ready;

   // A new error in the same cycle as error_clear survives the clear
   always_ff @(posedge clock) begin
      if (reset) begin
         r_err <= 3'b000;
         r_ovf <= 1'b0;
      end else begin
         r_err <= (error_clear ? 3'b000 : r_err) | w_err_set;
         r_ovf <= (error_clear ? 1'b0 : r_ovf) | w_ovf_set;
      end
   end

   assign error_flag     = r_err;
   assign rx_overflow    = r_ovf;
   assign tx_active_flag = (r_tx_state != TX_IDLE);
   assign rx_active_flag = (r_rx_state != RX_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_duplex_fifo.md
Name: uart_duplex_fifo

Overview:
Parametrised full-duplex UART channel with independent TX and RX serial engines. Each direction is buffered by a synchronous FIFO with a valid/ready interface. Data width, FIFO depth and baud divisor are configurable. Replaces chained single-frame duplex instances wherever the system needs buffered serial links, sticky error reporting and overflow detection.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 8, entries per FIFO; power of 2, minimum 2.
CLK_DIV, 4, clocks per oversample tick; minimum 1. Bit period = 16*CLK_DIV clocks.

Ports:
clock  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
parity_type  in  2  00 none, 01 odd, 10 even, 11 none. Must be static while either engine is active.
tx_data  in  DATA_WIDTH  word to transmit.
tx_valid  in  1  push request for tx_data.
tx_ready  out  1  TX FIFO not full.
rx_data  out  DATA_WIDTH  head of RX FIFO (first-word fall-through).
rx_valid  out  1  RX FIFO not empty.
rx_ready  in  1  pop request for RX FIFO.
rxd  in  1  asynchronous serial input; idle high.
txd  out  1  serial output; idle high.
tx_active_flag  out  1  TX engine not IDLE.
rx_active_flag  out  1  RX engine not IDLE.
error_flag  out  3  sticky error bits: [0] parity, [1] start, [2] stop.
rx_overflow  out  1  sticky; a frame was received while the RX FIFO was full.
error_clear  in  1  clears error_flag and rx_overflow.

Behaviour:
- Reset: txd=1; tx_ready=1; rx_valid=0; both flags 0; error_flag=0; rx_overflow=0; FIFOs emptied; tick counter=0; both FSMs IDLE. A reset mid-frame aborts the frame with no partial push.
- Tick generator: free-running counter 0..CLK_DIV-1. tick=1 on the cycle the counter equals CLK_DIV-1.
- FIFO push occurs when valid&&ready. Pop on an empty FIFO is ignored. A simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged. A full FIFO does not accept a push even when a pop happens in the same cycle.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty on a tick, pop the word into the shift register and go to START.
  - Each state lasts 16 ticks.
  - DATA shifts DATA_WIDTH bits, LSB first.
  - PARITY is skipped when parity is none.
  - After STOP: return to IDLE, or go directly to START if the FIFO is non-empty, giving back-to-back frames.
  - txd is 0 in START, the data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
- RX path:
  - rxd passes through a 2-flop synchronizer that resets to 1.
  - IDLE to START on a tick that sees the synchronized rxd at 0.
  - Mid-bit sample at tick 8 of START. If the sample is 1, set error_flag[1] and return to IDLE with no push.
  - After the start bit, sample every 16 ticks: DATA_WIDTH data bits LSB first, then parity if enabled, then stop.
  - Parity mismatch sets error_flag[0]. Stop sample of 0 sets error_flag[2].
  - Frames with a parity or stop error are still pushed.
  - Push occurs 1 cycle after the stop sample, then the FSM returns to IDLE.
  - If the FIFO is full at push, the frame is dropped and rx_overflow is set.
- Parity: even means the data bits plus the parity bit contain an even number of 1s; odd means they contain an odd number.
- error_clear: set has priority over clear in the same cycle.

Optional Feature:
UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the RX synchronizer input is the internal TX serial signal, txd is forced to 1, and external rxd is ignored. When loopback=0, behaviour is as without the macro.
- Undefined: the port is absent and the logic is not generated.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PARITY_NONE, PARITY_ODD, PARITY_EVEN;
  - OVERSAMPLE=16 and MID_SAMPLE=8;
  - tx_state_t and rx_state_t enums;
  - error bit indices ERR_PARITY=0, ERR_START=1, ERR_STOP=2.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH), instantiated twice. It uses pointers of width $clog2(DEPTH)+1 for full/empty detection.

Test Plan:
- CLK_DIV=1, even parity, push 0xA5, with txd externally wired to rxd:
  - txd low for 16 clocks, then 1,0,1,0,0,1,0,1 at 16 clocks each, parity 0, stop 1;
  - rx_valid rises with rx_data=0xA5 about 176 clocks after start;
  - error_flag stays 0.
- Odd parity configured, external rxd drives 0x3C with even-parity bit:
  - rx_data=0x3C pushed, error_flag=3'b001;
  - a later error_clear returns it to 0.
- rxd pulsed low for 4 clocks (CLK_DIV=1) -> error_flag[1]=1, rx_valid stays 0, rx_active_flag back to 0.
- FIFO_DEPTH=4, five frames 0x01..0x05 received with no pops -> rx_overflow=1; pops return 0x01..0x04 in order, then rx_valid=0.
- Push 8 words with tx_valid held high -> tx_ready=0 after the FIFO fills; frames are sent back-to-back with no idle bits between them.
- Assert reset mid-DATA -> next cycle txd=1, both flags 0, both FIFOs empty. With UART_LOOPBACK_EN and loopback=1: push 0x5A -> received 0x5A, txd constant 1.
